// File: rtl/ir_bus_monitor_pkg.sv
// Shared constants for the instruction-read bus monitor: error-bit layout and
// transaction id width.
package ir_bus_monitor_pkg;

  localparam int unsigned ERR_OVERFLOW      = 0;
  localparam int unsigned ERR_ORPHAN        = 1;
  localparam int unsigned ERR_ADDR_UNSTABLE = 2;
  localparam int unsigned ERR_DATA_UNSTABLE = 3;
  localparam int unsigned ERR_TIMEOUT       = 4;
  localparam int unsigned ERR_W             = 5;

  localparam int unsigned TXN_ID_W = 16;

endpackage

// File: rtl/ir_bus_monitor_fifo.sv
// Pending-address FIFO: combinational head, push accepted when full only if a
// pop happens in the same cycle.
module monitor_fifo #(
  parameter int unsigned width = 32,
  parameter int unsigned depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [width-1:0]         wdata,
  output logic [width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);

  localparam int unsigned aw = $clog2(depth);
  localparam int unsigned cw = aw + 1;

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wptr_q, rptr_q;
  logic [cw-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == cw'(depth));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ir_bus_monitor.sv
// Passive instruction-read bus monitor: pairs fetch addresses with returned
// words, emits one record per fetch and raises sticky protocol-error flags.
module ir_bus_monitor
  import ir_bus_monitor_pkg::*;
#(
  parameter int unsigned addr_width      = 32,
  parameter int unsigned inst_width      = 32,
  parameter int unsigned max_outstanding = 4,
  parameter int unsigned timeout_cycles  = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               ir_addr_valid,
  input  logic                               ir_addr_ready,
  input  logic [addr_width-1:0]              ir_addr,
  input  logic                               ir_data_valid,
  input  logic                               ir_data_ready,
  input  logic [inst_width-1:0]              ir_data,
  output logic                               txn_valid,
  output logic [addr_width-1:0]              txn_addr,
  output logic [inst_width-1:0]              txn_data,
  output logic [TXN_ID_W-1:0]                txn_id,
  output logic [$clog2(max_outstanding):0]   outstanding,
  output logic                               err_overflow,
  output logic                               err_orphan,
  output logic                               err_addr_unstable,
  output logic                               err_data_unstable,
  output logic                               err_timeout,
  output logic                               err_any
);

  localparam int unsigned tw = $clog2(timeout_cycles + 1);
  localparam logic [tw-1:0] tmo_max = tw'(timeout_cycles);

  logic                  addr_hs, data_hs, push_ok, pop_ok;
  logic                  fifo_full, fifo_empty;
  logic [addr_width-1:0] fifo_head;

  logic                  addr_wait_q, data_wait_q;
  logic [addr_width-1:0] addr_hold_q;
  logic [inst_width-1:0] data_hold_q;
  logic [tw-1:0]         tmo_q, tmo_d;
  logic [ERR_W-1:0]      err_q, err_d;
  logic                  txn_valid_q;
  logic [addr_width-1:0] txn_addr_q;
  logic [inst_width-1:0] txn_data_q;
  logic [TXN_ID_W-1:0]   txn_id_q, seq_q;

  assign addr_hs = ir_addr_valid & ir_addr_ready;
  assign data_hs = ir_data_valid & ir_data_ready;
  // No same-cycle bypass: a pop needs an entry already present.
  assign pop_ok  = data_hs & ~fifo_empty;
  assign push_ok = addr_hs & (~fifo_full | pop_ok);

  monitor_fifo #(
    .width (addr_width),
    .depth (max_outstanding)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop_ok),
    .wdata (ir_addr),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding)
  );

  always_comb begin
    if (data_hs || (outstanding == '0)) begin
      tmo_d = '0;
    end else if (tmo_q == tmo_max) begin
      tmo_d = tmo_q;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_comb begin
    err_d = err_q;
    err_d[ERR_OVERFLOW]      = err_q[ERR_OVERFLOW] | (addr_hs & ~push_ok);
    err_d[ERR_ORPHAN]        = err_q[ERR_ORPHAN] | (data_hs & fifo_empty);
    err_d[ERR_ADDR_UNSTABLE] = err_q[ERR_ADDR_UNSTABLE] |
                               (addr_wait_q & (!ir_addr_valid || (ir_addr != addr_hold_q)));
    err_d[ERR_DATA_UNSTABLE] = err_q[ERR_DATA_UNSTABLE] |
                               (data_wait_q & (!ir_data_valid || (ir_data != data_hold_q)));
    err_d[ERR_TIMEOUT]       = err_q[ERR_TIMEOUT] | (tmo_d == tmo_max);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_wait_q <= 1'b0;
      data_wait_q <= 1'b0;
      addr_hold_q <= '0;
      data_hold_q <= '0;
      tmo_q       <= '0;
      err_q       <= '0;
      txn_valid_q <= 1'b0;
      txn_addr_q  <= '0;
      txn_data_q  <= '0;
      txn_id_q    <= '0;
      seq_q       <= '0;
    end else begin
      addr_wait_q <= ir_addr_valid & ~ir_addr_ready;
      data_wait_q <= ir_data_valid & ~ir_data_ready;
      addr_hold_q <= ir_addr;
      data_hold_q <= ir_data;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      txn_valid_q <= pop_ok;
      if (pop_ok) begin
        txn_addr_q <= fifo_head;
        txn_data_q <= ir_data;
        txn_id_q   <= seq_q;
        seq_q      <= seq_q + 1'b1;
      end
    end
  end

  assign txn_valid         = txn_valid_q;
  assign txn_addr          = txn_addr_q;
  assign txn_data          = txn_data_q;
  assign txn_id            = txn_id_q;
  assign err_overflow      = err_q[ERR_OVERFLOW];
  assign err_orphan        = err_q[ERR_ORPHAN];
  assign err_addr_unstable = err_q[ERR_ADDR_UNSTABLE];
  assign err_data_unstable = err_q[ERR_DATA_UNSTABLE];
  assign err_timeout       = err_q[ERR_TIMEOUT];
  assign err_any           = |err_q;

endmodule

// File: tb/tb_ir_bus_monitor.sv
// Bench for ir_bus_monitor: directed scenarios plus random traffic, all checked
// against a queue-based transaction model.
module tb_ir_bus_monitor;

  localparam int MAXO = 4;
  localparam int TMO  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ir_addr_valid = 1'b0, ir_addr_ready = 1'b0;
  logic [31:0] ir_addr = '0;
  logic        ir_data_valid = 1'b0, ir_data_ready = 1'b0;
  logic [31:0] ir_data = '0;
  logic        txn_valid;
  logic [31:0] txn_addr, txn_data;
  logic [15:0] txn_id;
  logic [2:0]  outstanding;
  logic        err_overflow, err_orphan, err_addr_unstable, err_data_unstable;
  logic        err_timeout, err_any;

  ir_bus_monitor #(
    .addr_width      (32),
    .inst_width      (32),
    .max_outstanding (MAXO),
    .timeout_cycles  (TMO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .ir_addr_valid     (ir_addr_valid),
    .ir_addr_ready     (ir_addr_ready),
    .ir_addr           (ir_addr),
    .ir_data_valid     (ir_data_valid),
    .ir_data_ready     (ir_data_ready),
    .ir_data           (ir_data),
    .txn_valid         (txn_valid),
    .txn_addr          (txn_addr),
    .txn_data          (txn_data),
    .txn_id            (txn_id),
    .outstanding       (outstanding),
    .err_overflow      (err_overflow),
    .err_orphan        (err_orphan),
    .err_addr_unstable (err_addr_unstable),
    .err_data_unstable (err_data_unstable),
    .err_timeout       (err_timeout),
    .err_any           (err_any)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pending addresses as a queue, errors as a bit vector
  // {timeout, data_unstable, addr_unstable, orphan, overflow}.
  logic [31:0] mq[$];
  int          m_seq;
  int          m_wait;
  logic        m_valid;
  logic [31:0] m_addr, m_data;
  logic [15:0] m_id;
  logic [4:0]  m_err;
  logic        a_pend, d_pend;
  logic [31:0] a_prev, d_prev;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic model_edge();
    logic a_hs, d_hs, popped;
    int   sz;
    if (rst) begin
      mq.delete();
      m_seq = 0; m_wait = 0; m_valid = 0; m_addr = 0; m_data = 0; m_id = 0;
      m_err = 0; a_pend = 0; d_pend = 0; a_prev = 0; d_prev = 0;
      return;
    end
    a_hs = ir_addr_valid & ir_addr_ready;
    d_hs = ir_data_valid & ir_data_ready;
    sz   = mq.size();
    if (a_pend && (!ir_addr_valid || ir_addr != a_prev)) m_err[2] = 1'b1;
    if (d_pend && (!ir_data_valid || ir_data != d_prev)) m_err[3] = 1'b1;
    a_pend = ir_addr_valid & ~ir_addr_ready;  a_prev = ir_addr;
    d_pend = ir_data_valid & ~ir_data_ready;  d_prev = ir_data;
    popped  = d_hs && (sz > 0);
    m_valid = popped;
    if (popped) begin
      m_addr = mq.pop_front();
      m_data = ir_data;
      m_id   = m_seq[15:0];
      m_seq  = m_seq + 1;
    end
    if (d_hs && sz == 0) m_err[1] = 1'b1;
    if (a_hs) begin
      if (sz < MAXO || popped) mq.push_back(ir_addr);
      else m_err[0] = 1'b1;
    end
    if (d_hs || sz == 0) m_wait = 0;
    else if (m_wait < TMO) m_wait++;
    if (m_wait == TMO) m_err[4] = 1'b1;
  endtask

  task automatic compare_all();
    check("txn_valid", 64'(txn_valid), 64'(m_valid));
    check("txn_addr", 64'(txn_addr), 64'(m_addr));
    check("txn_data", 64'(txn_data), 64'(m_data));
    check("txn_id", 64'(txn_id), 64'(m_id));
    check("outstanding", 64'(outstanding), 64'(mq.size()));
    check("err_flags", 64'({err_timeout, err_data_unstable, err_addr_unstable,
                            err_orphan, err_overflow}), 64'(m_err));
    check("err_any", 64'(err_any), 64'(|m_err));
  endtask

  // Drive one cycle of bus inputs, let the edge happen, check after it.
  task automatic step(input logic av, input logic ar, input logic [31:0] a,
                      input logic dv, input logic dr, input logic [31:0] d);
    ir_addr_valid = av; ir_addr_ready = ar; ir_addr = a;
    ir_data_valid = dv; ir_data_ready = dr; ir_data = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check("reset_outstanding", 64'(outstanding), 64'd0);
    check("reset_err_any", 64'(err_any), 64'd0);

    // Single fetch
    step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    idle();
    idle();
    check("single_pending", 64'(outstanding), 64'd1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h13);
    check("single_valid", 64'(txn_valid), 64'd1);
    check("single_addr", 64'(txn_addr), 64'h100);
    check("single_data", 64'(txn_data), 64'h13);
    check("single_id", 64'(txn_id), 64'd0);
    idle();
    check("single_pulse_end", 64'(txn_valid), 64'd0);

    // Pipelined fetches and overflow
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'(i * 4), 1'b0, 1'b0, 32'h0);
    check("pipe_peak", 64'(outstanding), 64'd4);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1000 + 32'(i));
      check("pipe_valid", 64'(txn_valid), 64'd1);
      check("pipe_id", 64'(txn_id), 64'(i));
      check("pipe_addr", 64'(txn_addr), 64'(i * 4));
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'h20 + 32'(i), 1'b0, 1'b0, 32'h0);
    check("full_no_ovf", 64'(err_overflow), 64'd0);
    step(1'b1, 1'b1, 32'h80, 1'b1, 1'b1, 32'h55);  // push+pop while full is legal
    check("full_pushpop_no_ovf", 64'(err_overflow), 64'd0);
    step(1'b1, 1'b1, 32'h84, 1'b0, 1'b0, 32'h0);
    check("overflow_flag", 64'(err_overflow), 64'd1);

    // Orphan response with simultaneous push
    do_reset();
    step(1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 32'hdead);
    check("orphan_flag", 64'(err_orphan), 64'd1);
    check("orphan_no_txn", 64'(txn_valid), 64'd0);
    check("orphan_outstanding", 64'(outstanding), 64'd1);

    // Reset mid-operation discards pending work silently
    step(1'b1, 1'b1, 32'h204, 1'b0, 1'b0, 32'h0);
    do_reset();
    check("midrst_outstanding", 64'(outstanding), 64'd0);
    check("midrst_err_any", 64'(err_any), 64'd0);
    step(1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h77);
    check("midrst_id", 64'(txn_id), 64'd0);
    check("midrst_addr", 64'(txn_addr), 64'h300);
    check("midrst_no_orphan", 64'(err_orphan), 64'd0);

    // Stability violations
    do_reset();
    step(1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0);
    check("addr_unstable", 64'(err_addr_unstable), 64'd1);
    check("data_stable_so_far", 64'(err_data_unstable), 64'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h99);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h99);
    check("data_unstable", 64'(err_data_unstable), 64'd1);

    // Timeout at the 64th waiting cycle
    do_reset();
    step(1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < TMO - 1; i++) idle();
    check("tmo_before", 64'(err_timeout), 64'd0);
    idle();
    check("tmo_hit", 64'(err_timeout), 64'd1);
    do_reset();
    step(1'b1, 1'b1, 32'h504, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < TMO - 1; i++) idle();
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h33);
    check("tmo_just_in_time", 64'(err_timeout), 64'd0);
    check("tmo_late_txn", 64'(txn_valid), 64'd1);

    // Random protocol-legal traffic: no error may appear
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      logic        av, ar, dv, dr;
      logic [31:0] a, d;
      av = a_pend ? 1'b1 : 1'($urandom_range(0, 1));
      a  = a_pend ? a_prev : $urandom();
      ar = (mq.size() < MAXO) ? 1'($urandom_range(0, 1)) : 1'b0;
      dv = d_pend ? 1'b1 : ((mq.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0);
      d  = d_pend ? d_prev : $urandom();
      dr = 1'($urandom_range(0, 1));
      step(av, ar, a, dv, dr, d);
    end
    check("legal_no_errors", 64'(err_any), 64'd0);

    // Random unconstrained traffic with occasional resets
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7));
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ir_bus_monitor.md
Name: ir_bus_monitor

Overview:
- Passive monitor on the CPU instruction-read bus. It sits between the bus and the CPU checker.
- Pairs each accepted fetch address with its returned instruction word.
- Emits one transaction record per completed fetch for the checker to consume.
- Raises sticky protocol-violation flags for valid/ready misuse, orphan responses, overflow and response timeout.
- Never drives the bus.

Parameters:
- addr_width, 32, fetch address width.
- inst_width, 32, instruction data width.
- max_outstanding, 4, depth of the pending-address FIFO; must be a power of 2 and ≥2.
- timeout_cycles, 64, maximum cycles a pending request may wait for its response.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- ir_addr_valid  input  1  bus address-channel valid.
- ir_addr_ready  input  1  bus address-channel ready.
- ir_addr  input  addr_width  fetch address.
- ir_data_valid  input  1  bus data-channel valid.
- ir_data_ready  input  1  bus data-channel ready.
- ir_data  input  inst_width  returned instruction.
- txn_valid  output  1  one-cycle pulse: a fetch has completed.
- txn_addr  output  addr_width  address of the completed fetch.
- txn_data  output  inst_width  instruction of the completed fetch.
- txn_id  output  16  sequence number of the completed fetch; 0 for the first.
- outstanding  output  clog2(max_outstanding)+1  count of accepted-but-unanswered addresses.
- err_overflow  output  1  sticky flag.
- err_orphan  output  1  sticky flag.
- err_addr_unstable  output  1  sticky flag.
- err_data_unstable  output  1  sticky flag.
- err_timeout  output  1  sticky flag.
- err_any  output  1  OR of all err_* flags.

Behaviour:
- Reset (rst=1 at posedge) clears:
  - FIFO (empty), outstanding=0, txn_id counter=0.
  - txn_valid=0, txn_addr=0, txn_data=0, txn_id=0.
  - All err_* and err_any to 0, timeout counter, stability registers.
  - Reset mid-transaction discards pending addresses silently; no error is raised.
- Address accept: ir_addr_valid & ir_addr_ready at posedge pushes ir_addr into the FIFO.
  - If the FIFO is full, the push is dropped and err_overflow is set.
- Data accept: ir_data_valid & ir_data_ready at posedge.
  - If the FIFO is non-empty: pop the head. In the next cycle drive txn_valid=1, txn_addr=popped address, txn_data=captured ir_data, txn_id=sequence counter. Then increment the counter; it wraps 0xFFFF→0.
  - If the FIFO is empty, set err_orphan and emit no txn.
- Latency: txn_valid asserts exactly 1 cycle after the data handshake.
- Back-to-back data handshakes give txn_valid on consecutive cycles.
- Simultaneous push and pop in one cycle:
  - Both take effect and outstanding is unchanged.
  - There is no same-cycle bypass. A pop with the FIFO empty is an orphan even when a push occurs in the same cycle.
  - A pop when full plus a push is legal; no overflow.
- Stability checks (each channel checked independently):
  - If valid=1 and ready=0 at a posedge, then at the next posedge valid must still be 1 and the payload must be unchanged.
  - A violation sets err_addr_unstable or err_data_unstable respectively.
- Timeout:
  - A counter increments each cycle while outstanding>0 and no data handshake occurs.
  - It clears on any data handshake or when outstanding=0.
  - When it reaches timeout_cycles, err_timeout is set and the counter saturates.
- Error flags set the cycle after the offending posedge and hold until rst.
- The monitor keeps operating after errors.
- err_any is combinational OR of the registered flags.

Decomposition:
- Shared package/header ir_bus_monitor_pkg holds:
  - Error-bit index constants: ERR_OVERFLOW=0, ERR_ORPHAN=1, ERR_ADDR_UNSTABLE=2, ERR_DATA_UNSTABLE=3, ERR_TIMEOUT=4.
  - The txn_id width constant (16).
- Sub-module monitor_fifo: synchronous FIFO with parameters width and depth.
  - Inputs: push, pop, wdata.
  - Outputs: rdata (head, combinational), full, empty, count.
  - Simultaneous push/pop is allowed when full.

Test Plan:
- Single fetch: addr 0x0000_0100 accepted at cycle 2, data 0x0000_0013 accepted at cycle 5 → txn_valid at cycle 6 with txn_addr=0x100, txn_data=0x13, txn_id=0; outstanding 1 during cycles 3–5, then 0; no errors.
- Pipelined: 4 addresses (0x0,0x4,0x8,0xC) back-to-back, then 4 data words back-to-back → 4 consecutive txn pulses in order, ids 0–3; outstanding peaks at 4; a 5th address while full → err_overflow=1.
- Orphan: data handshake with outstanding=0, including a cycle with a simultaneous address push → err_orphan=1, no txn_valid, outstanding=1 after.
- Stability: ir_addr_valid=1, ready=0, addr 0x40 then 0x44 next cycle → err_addr_unstable=1; same pattern with valid dropping on the data channel → err_data_unstable=1.
- Timeout: one address accepted, no data for 64 cycles → err_timeout=1 at the 64th waiting cycle. Repeat with data arriving at cycle 63 → no error.
- Reset mid-operation: 2 pending addresses plus errors set, pulse rst for 1 cycle → all outputs 0; next fetch yields txn_id=0 and no orphan error.
